// File: rtl/my_logic_pkg.sv
// Shared types and defaults for the bit-serial logic unit and its shift registers.
package my_logic_pkg;

  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NOT} logic_op_t;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} ser_state_t;

  localparam int WIDTH_DEFAULT = 16;

endpackage

// File: rtl/my_shift_reg_16.sv
// Parallel-load right-shift register; sin feeds the MSB on each shift.
// Operand registers tie sin low; the result register shifts the gate output in.
module my_shift_reg_16
  import my_logic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign q_next[gi] = q_reg[gi+1];
    end
  endgenerate
  assign q_next[WIDTH-1] = sin;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end else if (shift) begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/my_serial_logic_16.sv
// Bit-serial WIDTH-bit AND/OR/XOR/NOT unit, one bit per clock, LSB first.
// Define MY_SERIAL_LOGIC_FLAGS_EN to add registered zr/ng result flags.
module my_serial_logic_16
  import my_logic_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
`ifdef MY_SERIAL_LOGIC_FLAGS_EN
  ,
  output logic             zr,
  output logic             ng
`endif
);

  ser_state_t       state_reg, state_next;
  logic_op_t        op_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             accept, step, last_bit, r;

  assign accept   = in_valid && (state_reg == S_IDLE);
  assign step     = (state_reg == S_SHIFT);
  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

  always_comb begin
    r = 1'b0;
    case (op_reg)
      OP_AND:  r = a_q[0] & b_q[0];
      OP_OR:   r = a_q[0] | b_q[0];
      OP_XOR:  r = a_q[0] ^ b_q[0];
      OP_NOT:  r = ~a_q[0];
      default: r = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      op_reg    <= OP_AND;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg  <= logic_op_t'(op);
        cnt_reg <= '0;
      end else if (step) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // in_ready is derived from state alone, so a DONE-cycle in_valid can never be taken.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_bit) state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  my_shift_reg_16 #(.WIDTH(WIDTH)) u_a_sr (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (step),
    .sin   (1'b0),
    .d     (a),
    .q     (a_q)
  );

  my_shift_reg_16 #(.WIDTH(WIDTH)) u_b_sr (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (step),
    .sin   (1'b0),
    .d     (b),
    .q     (b_q)
  );

  // Result fills from the top so that after WIDTH shifts bit i sits at position i.
  my_shift_reg_16 #(.WIDTH(WIDTH)) u_res_sr (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (step),
    .sin   (r),
    .d     ({WIDTH{1'b0}}),
    .q     (res_q)
  );

  assign out = res_q;

`ifdef MY_SERIAL_LOGIC_FLAGS_EN
  logic [WIDTH-1:0] res_next;
  logic             zr_reg, ng_reg;

  assign res_next = {r, res_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      zr_reg <= 1'b0;
      ng_reg <= 1'b0;
    end else if (step && last_bit) begin
      zr_reg <= (res_next == '0);
      ng_reg <= r;
    end
  end

  assign zr = zr_reg;
  assign ng = ng_reg;
`endif

endmodule

// File: tb/tb_my_serial_logic_16.sv
// Directed bench for my_serial_logic_16: hand-computed results, latency, backpressure, reset.
module tb_my_serial_logic_16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        busy;
`ifdef MY_SERIAL_LOGIC_FLAGS_EN
  logic        zr, ng;
`endif

  int n_cmp = 0;
  int n_err = 0;

  my_serial_logic_16 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
`ifdef MY_SERIAL_LOGIC_FLAGS_EN
    ,
    .zr        (zr),
    .ng        (ng)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Step one edge and settle outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until out_valid rises; 16 means visible right after edge N+16, captured at N+17.
  task automatic wait_valid(input string tag, output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    check({tag, "_latency"}, cnt, 16);
  endtask

  // Full transaction with out_ready held high.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [1:0] opv, input logic [15:0] exp);
    int cnt;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    a = av; b = bv; op = opv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(tag, cnt);
    check({tag, "_out"}, out, exp);
    tick();
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
    $display("txn %s a=%h b=%h op=%0d out=%h", tag, av, bv, opv, out);
  endtask

  initial begin
    int cnt;
    int bad;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 2'd0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out", out, 16'h0000);
`ifdef MY_SERIAL_LOGIC_FLAGS_EN
    check("rst_zr", zr, 0);
    check("rst_ng", ng, 0);
`endif

    run_op("or_0_ffff", 16'h0000, 16'hFFFF, 2'd1, 16'hFFFF);
    run_op("or_e000", 16'hE000, 16'hA000, 2'd1, 16'hE000);
    run_op("or_e00c", 16'h000C, 16'hE000, 2'd1, 16'hE00C);

    // Back-to-back: second pair presented from the cycle after the first is taken.
    @(negedge clk);
    a = 16'hE000; b = 16'hA000; op = 2'd1; in_valid = 1'b1;
    tick();
    a = 16'h000C; b = 16'hE000;
    bad = 0; cnt = 0;
    while (!out_valid && cnt < 40) begin
      if (in_ready) bad++;
      tick();
      cnt++;
    end
    if (in_ready) bad++;
    check("b2b_latency1", cnt, 16);
    check("b2b_ready_low", bad, 0);
    check("b2b_out1", out, 16'hE000);
    $display("txn b2b_first out=%h", out);
    tick();
    check("b2b_idle_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("b2b_second_busy", busy, 1);
    wait_valid("b2b_second", cnt);
    check("b2b_out2", out, 16'hE00C);
    $display("txn b2b_second out=%h", out);
    tick();
    check("b2b_valid_drop", out_valid, 0);

    run_op("and_5a3c", 16'h5A3C, 16'h0FF0, 2'd0, 16'h0A30);
    run_op("xor_5a3c", 16'h5A3C, 16'h0FF0, 2'd2, 16'h55CC);
    run_op("not_5a3c", 16'h5A3C, 16'hFFFF, 2'd3, 16'hA5C3);

    // Backpressure: hold DONE for 5 cycles while poking in_valid.
    @(negedge clk);
    out_ready = 1'b0;
    a = 16'h1234; b = 16'hFFFF; op = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("bp", cnt);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a = 16'h0F0F; op = 2'd0;
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_out", out, 16'hEDCB);
      check("bp_hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_valid_drop", out_valid, 0);
    check("bp_ready_back", in_ready, 1);
    check("bp_out_kept", out, 16'hEDCB);
    tick();
    check("bp_no_capture", busy, 0);
    $display("txn backpressure out=%h", out);

    // Reset during SHIFT discards the operation.
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; op = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    check("mid_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out", out, 16'h0000);
    bad = 0;
    repeat (20) begin
      tick();
      if (out_valid) bad++;
    end
    check("mid_rst_no_result", bad, 0);
    $display("txn reset_mid_shift discarded");
    run_op("and_after_rst", 16'hFFFF, 16'h00FF, 2'd0, 16'h00FF);

    run_op("and_zero", 16'hF0F0, 16'h0F0F, 2'd0, 16'h0000);
`ifdef MY_SERIAL_LOGIC_FLAGS_EN
    check("and_zero_zr", zr, 1);
    check("and_zero_ng", ng, 0);
`endif
    run_op("or_neg", 16'h8000, 16'h0001, 2'd1, 16'h8001);
`ifdef MY_SERIAL_LOGIC_FLAGS_EN
    check("or_neg_zr", zr, 0);
    check("or_neg_ng", ng, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
